// File: rtl/matrix_result_streamer.sv
// Captures a packed result matrix on start and streams it row-major over valid/ready.
// One element per cycle at most. Output registers hold steady while downstream stalls.
module matrix_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat,
    output logic                                      busy,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [RW-1:0]                             m_row,
    output logic [CW-1:0]                             m_col,
    output logic                                      m_last,
    output logic                                      done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state_reg, state_next;

    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] shadow_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [RW-1:0]         row_reg, row_next;
    logic [CW-1:0]         col_reg, col_next;
    logic                  last_reg, done_reg;
    logic                  accept, handshake;

    // valid and busy come straight from the state register, never from m_ready
    assign busy      = (state_reg == SEND);
    assign m_valid   = (state_reg == SEND);
    assign m_data    = data_reg;
    assign m_row     = row_reg;
    assign m_col     = col_reg;
    assign m_last    = last_reg;
    assign done      = done_reg;
    assign accept    = start && (state_reg == IDLE);
    assign handshake = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SEND;
            SEND:    if (handshake && last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row-major advance: column wraps into the next row
    always_comb begin
        row_next = row_reg;
        col_next = col_reg + 1'b1;
        if (col_reg == CW'(COLS - 1)) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (accept) begin
            shadow_reg <= mat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            row_reg  <= '0;
            col_reg  <= '0;
            last_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                // first element comes from the live input; shadow is loaded the same edge
                data_reg <= mat[0][0];
                row_reg  <= '0;
                col_reg  <= '0;
                last_reg <= (ROWS == 1) && (COLS == 1);
            end else if (handshake) begin
                if (last_reg) begin
                    last_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    data_reg <= shadow_reg[row_next][col_next];
                    row_reg  <= row_next;
                    col_reg  <= col_next;
                    last_reg <= (row_next == RW'(ROWS - 1)) && (col_next == CW'(COLS - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Randomised bench for matrix_result_streamer: a 2x2x8 instance and a 3x1x16 instance,
// checked against an expected-beat queue built row-major from each captured matrix.
module tb_matrix_result_streamer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2x2, 8-bit instance
    logic                   start, m_ready;
    logic [1:0][1:0][7:0]   mat;
    logic                   busy, m_valid, m_last, done;
    logic [7:0]             m_data;
    logic [0:0]             m_row, m_col;

    // 3x1, 16-bit instance
    logic                   start3, m_ready3;
    logic [2:0][0:0][15:0]  mat3;
    logic                   busy3, m_valid3, m_last3, done3;
    logic [15:0]            m_data3;
    logic [1:0]             m_row3;
    logic [0:0]             m_col3;

    matrix_result_streamer dut (
        .clk(clk), .rst(rst), .start(start), .mat(mat), .busy(busy),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_row(m_row), .m_col(m_col), .m_last(m_last), .done(done)
    );

    matrix_result_streamer #(.DATA_WIDTH(16), .ROWS(3), .COLS(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mat(mat3), .busy(busy3),
        .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready3),
        .m_row(m_row3), .m_col(m_col3), .m_last(m_last3), .done(done3)
    );

    typedef struct {
        logic [15:0] d;
        int          r;
        int          c;
        bit          l;
    } beat_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a matrix with start high; caller must be at a negedge
    task automatic begin_frame(input logic [7:0] m [4]);
        start = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                mat[r][c] = m[r*2 + c];
    endtask

    // Stream the frame started by begin_frame.
    // mode 0: always ready, 1: fixed pattern 1,0,0,1,0,1,1, 2: random.
    // poke: keep raising start with junk data while busy (must be ignored).
    task automatic stream(input logic [7:0] m [4], input int mode, input bit poke);
        beat_t q[$];
        bit    pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int    cyc = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                q.push_back('{d: 16'(m[r*2 + c]), r: r, c: c, l: (r == 1 && c == 1)});
        @(posedge clk);
        @(negedge clk);
        while (q.size() > 0 && cyc < 200) begin
            start = 1'b0;
            check("valid", 32'(m_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("done_mid", 32'(done), 32'd0);
            check("data", 32'(m_data), 32'(q[0].d));
            check("row", 32'(m_row), 32'(q[0].r));
            check("col", 32'(m_col), 32'(q[0].c));
            check("last", 32'(m_last), 32'(q[0].l));
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[cyc % 7];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke) begin
                start = 1'b1;
                mat   = $urandom;
            end
            @(posedge clk);
            if (m_ready) begin
                $display("beat r=%0d c=%0d data=%0h last=%0d", q[0].r, q[0].c, q[0].d, q[0].l);
                void'(q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) check("timeout", 32'd1, 32'd0);
        check("done", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("valid_end", 32'(m_valid), 32'd0);
        check("last_end", 32'(m_last), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(m_valid), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
    endtask

    logic [7:0] m_seq [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] m_ff  [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] m_rnd [4];
    logic [15:0] v3 [3] = '{16'hAAAA, 16'h5555, 16'h1234};

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; mat = '0;
        start3 = 1'b0; m_ready3 = 1'b0; mat3 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state and idle behaviour
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_row", 32'(m_row), 32'd0);
        check("rst_col", 32'(m_col), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        idle(10);

        // basic frame, then backpressure
        begin_frame(m_seq);
        stream(m_seq, 0, 1'b0);
        idle(2);
        begin_frame(m_seq);
        stream(m_seq, 1, 1'b0);
        idle(1);

        // start while busy ignored; back-to-back start in done cycle accepted
        begin_frame(m_seq);
        stream(m_seq, 2, 1'b1);
        begin_frame(m_ff);
        stream(m_ff, 0, 1'b0);
        idle(1);

        // reset mid-stream after two elements accepted
        begin_frame(m_seq);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_data", 32'(m_data), 32'h03);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(m_data), 32'd0);
        check("arst_row", 32'(m_row), 32'd0);
        check("arst_last", 32'(m_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        begin_frame(m_seq);
        stream(m_seq, 0, 1'b0);
        idle(1);

        // random frames with random stalls and ignored starts
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) m_rnd[i] = 8'($urandom);
            begin_frame(m_rnd);
            stream(m_rnd, 2, f[0]);
            if (f[1]) idle(1);
        end

        // 3x1 16-bit instance
        begin
            int k = 0;
            int cyc = 0;
            start3 = 1'b1;
            for (int r = 0; r < 3; r++) mat3[r][0] = v3[r];
            m_ready3 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start3 = 1'b0;
            while (k < 3 && cyc < 50) begin
                check("valid3", 32'(m_valid3), 32'd1);
                check("data3", 32'(m_data3), 32'(v3[k]));
                check("row3", 32'(m_row3), 32'(k));
                check("col3", 32'(m_col3), 32'd0);
                check("last3", 32'(m_last3), 32'(k == 2));
                m_ready3 = 1'($urandom_range(0, 1));
                @(posedge clk);
                if (m_ready3) begin
                    $display("beat3 r=%0d data=%0h", k, v3[k]);
                    k++;
                end
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 50) check("timeout3", 32'd1, 32'd0);
            check("done3", 32'(done3), 32'd1);
            check("busy3_end", 32'(busy3), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
